// File: rtl/dbus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the CPU data bus.
// DATA pushes bytes into a small TX FIFO; STATUS/CTRL registers and a registered level irq.
module dbus_uart_tx #(
  parameter int                         DATA_DBUS_WIDTH = 32,
  parameter int                         ADDR_DBUS_WIDTH = 32,
  parameter logic [ADDR_DBUS_WIDTH-1:0] BASE_ADDR       = 32'h0001_0000,
  parameter int                         CLK_DIV         = 16,
  parameter int                         FIFO_DEPTH      = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [ADDR_DBUS_WIDTH-1:0] i_mem_addr,
  input  logic [DATA_DBUS_WIDTH-1:0] i_mem_wdata,
  input  logic                       i_mem_we,
  output logic [DATA_DBUS_WIDTH-1:0] o_mem_rdata,
  output logic                       o_sel,
  output logic                       o_txd,
  output logic                       o_irq
);
  // state   | meaning
  // S_IDLE  | line high, waiting for enable and a queued byte
  // S_START | start bit (low) for CLK_DIV clocks
  // S_DATA  | 8 data bits, LSB first, CLK_DIV clocks each
  // S_STOP  | stop bit (high); may chain straight into the next START

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BAUD_LOAD = BW'(CLK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        state, state_nxt;
  logic [BW-1:0] baud, baud_nxt;
  logic [2:0]    bit_cnt, bit_cnt_nxt;
  logic [7:0]    shift, shift_nxt;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, push, push_ok, pop;
  logic [7:0]    fifo_head;

  logic          enable, irq_en, overflow, busy;
  logic          wr_en, baud_end;
  logic [1:0]    reg_idx;
  logic          unused_bits;

  assign o_sel       = (i_mem_addr[ADDR_DBUS_WIDTH-1:4] == BASE_ADDR[ADDR_DBUS_WIDTH-1:4]);
  assign reg_idx     = i_mem_addr[3:2];
  assign wr_en       = i_mem_we && o_sel;
  assign unused_bits = ^{i_mem_addr[1:0], i_mem_wdata};

  assign full      = (count == CW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign push      = wr_en && (reg_idx == 2'd0);
  // A push into a full FIFO still lands when a pop frees the slot in the same cycle.
  assign push_ok   = push && (!full || pop);
  assign fifo_head = mem[rd_ptr];
  assign busy      = (state != S_IDLE) || !empty;
  assign baud_end  = (baud == '0);

  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr] <= i_mem_wdata[7:0];
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      if (push_ok && !pop)      count <= count + CW'(1);
      else if (!push_ok && pop) count <= count - CW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      enable   <= 1'b0;
      irq_en   <= 1'b0;
      overflow <= 1'b0;
      o_irq    <= 1'b0;
    end else begin
      if (wr_en && reg_idx == 2'd2) begin
        enable <= i_mem_wdata[0];
        irq_en <= i_mem_wdata[1];
      end
      if (push && full && !pop)
        overflow <= 1'b1;
      else if (wr_en && reg_idx == 2'd1 && i_mem_wdata[3])
        overflow <= 1'b0;
      o_irq <= irq_en && empty && (state == S_IDLE);
    end
  end

  always_comb begin
    o_mem_rdata = '0;
    case (reg_idx)
      2'd1:    o_mem_rdata[3:0] = {overflow, busy, empty, full};
      2'd2:    o_mem_rdata[1:0] = {irq_en, enable};
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state   <= S_IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      state   <= state_nxt;
      baud    <= baud_nxt;
      bit_cnt <= bit_cnt_nxt;
      shift   <= shift_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    baud_nxt    = baud;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    case (state)
      S_IDLE: begin
        if (pop) begin
          state_nxt = S_START;
          baud_nxt  = BAUD_LOAD;
          shift_nxt = fifo_head;
        end
      end
      S_START: begin
        if (baud_end) begin
          state_nxt   = S_DATA;
          baud_nxt    = BAUD_LOAD;
          bit_cnt_nxt = 3'd0;
        end else begin
          baud_nxt = baud - BW'(1);
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_nxt    = BAUD_LOAD;
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = S_STOP;
          else                 shift_nxt = {1'b0, shift[7:1]};
        end else begin
          baud_nxt = baud - BW'(1);
        end
      end
      S_STOP: begin
        if (baud_end) begin
          if (pop) begin
            state_nxt = S_START;
            baud_nxt  = BAUD_LOAD;
            shift_nxt = fifo_head;
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          baud_nxt = baud - BW'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    pop   = 1'b0;
    o_txd = 1'b1;
    case (state)
      S_IDLE:  pop = enable && !empty;
      S_START: o_txd = 1'b0;
      S_DATA:  o_txd = shift[0];
      S_STOP:  pop = baud_end && enable && !empty;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dbus_uart_tx.sv
// Testbench for dbus_uart_tx: random bytes checked against an ideal 8N1 waveform model,
// plus register, overflow, interrupt and reset scenarios.
module tb_dbus_uart_tx;
  localparam int DIV = 4;
  localparam logic [31:0] A_DATA = 32'h0001_0000;
  localparam logic [31:0] A_STAT = 32'h0001_0004;
  localparam logic [31:0] A_CTRL = 32'h0001_0008;
  localparam logic [31:0] A_RSVD = 32'h0001_000C;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata, rdata;
  logic        we, sel, txd, irq;
  int          n_checks = 0;
  int          n_pass = 0;

  dbus_uart_tx #(.CLK_DIV(DIV), .FIFO_DEPTH(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_mem_addr(addr), .i_mem_wdata(wdata),
    .i_mem_we(we), .o_mem_rdata(rdata), .o_sel(sel), .o_txd(txd), .o_irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0; addr = 32'h0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr = a; we = 1'b0;
    #1;
    d = rdata;
    addr = 32'h0;
  endtask

  // Called at the negedge right after the edge that makes a byte eligible to start.
  // Expects the start bit after the next edge, then captures all frames contiguously.
  task automatic run_frames(input string name, input logic [7:0] bytes[$],
                            input int inj_a, input logic [31:0] inj_a_addr, input logic [31:0] inj_a_dat,
                            input int inj_b, input logic [31:0] inj_b_addr, input logic [31:0] inj_b_dat,
                            input int probe_at, input logic [3:0] probe_exp, output int irq_hi);
    logic        s[$];
    logic [31:0] rd;
    logic [9:0]  fr;
    logic [7:0]  rx;
    int          nsamp, bad, t;
    irq_hi = 0;
    nsamp = bytes.size() * 10 * DIV;
    n_checks++;
    if (txd !== 1'b1) $display("FAIL %s pre_start_txd: got %b want 1", name, txd);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (txd !== 1'b0) $display("FAIL %s start_latency: txd got %b want 0", name, txd);
    else n_pass++;
    t = 0;
    while (txd !== 1'b0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (txd !== 1'b0) begin
      $display("FAIL %s start_timeout: no start bit within 50 cycles", name);
      return;
    end
    for (int j = 0; j < nsamp; j++) begin
      if (j > 0) @(negedge clk);
      if (j == inj_a) begin
        addr = inj_a_addr; wdata = inj_a_dat; we = 1'b1;
      end else if (j == inj_b) begin
        addr = inj_b_addr; wdata = inj_b_dat; we = 1'b1;
      end else begin
        we = 1'b0; addr = 32'h0;
        if (j == probe_at) begin
          bus_read(A_STAT, rd);
          n_checks++;
          if (rd !== {28'h0, probe_exp}) $display("FAIL %s probe_status: got 0x%0h want 0x%0h", name, rd, probe_exp);
          else n_pass++;
        end
      end
      s.push_back(txd);
      if (irq) irq_hi++;
    end
    we = 1'b0; addr = 32'h0;
    for (int f = 0; f < bytes.size(); f++) begin
      fr = {1'b1, bytes[f], 1'b0};
      bad = 0;
      for (int j = 0; j < 10 * DIV; j++)
        if (s[f*10*DIV + j] !== fr[j/DIV]) bad++;
      for (int i = 0; i < 8; i++) rx[i] = s[f*10*DIV + (i+1)*DIV + DIV/2];
      n_checks++;
      if (bad != 0)
        $display("FAIL %s frame%0d: %0d bad samples, mid-bit byte 0x%02h want 0x%02h", name, f, bad, rx, bytes[f]);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    rst = 1'b0; addr = 32'h0; wdata = 32'h0; we = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (txd !== 1'b1) $display("FAIL reset_txd: got %b want 1", txd); else n_pass++;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq); else n_pass++;
    bus_read(A_STAT, rd);
    n_checks++;
    if (rd !== 32'h2) $display("FAIL reset_status: got 0x%0h want 0x2", rd); else n_pass++;
    bus_read(A_CTRL, rd);
    n_checks++;
    if (rd !== 32'h0) $display("FAIL reset_ctrl: got 0x%0h want 0x0", rd); else n_pass++;
  endtask

  task automatic test_addr_decode();
    logic [31:0] rd;
    logic [31:0] outs[3] = '{32'h0001_0010, 32'h0001_0018, 32'h0000_0008};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      addr = outs[i]; wdata = 32'h3; we = 1'b1;
      #1;
      n_checks++;
      if (sel !== 1'b0) $display("FAIL sel_outside 0x%0h: got %b want 0", outs[i], sel); else n_pass++;
      @(negedge clk);
      we = 1'b0; addr = 32'h0;
    end
    bus_read(A_CTRL, rd);
    n_checks++;
    if (rd !== 32'h0) $display("FAIL outside_ctrl: got 0x%0h want 0x0", rd); else n_pass++;
    bus_read(A_STAT, rd);
    n_checks++;
    if (rd !== 32'h2) $display("FAIL outside_status: got 0x%0h want 0x2", rd); else n_pass++;
    bus_write(32'h0001_000A, 32'h2);
    bus_read(A_CTRL, rd);
    n_checks++;
    if (rd !== 32'h2) $display("FAIL ctrl_alias_lowbits: got 0x%0h want 0x2", rd); else n_pass++;
    bus_write(A_RSVD, 32'hFFFF_FFFF);
    bus_read(A_RSVD, rd);
    n_checks++;
    if (rd !== 32'h0) $display("FAIL reserved_read: got 0x%0h want 0x0", rd); else n_pass++;
    bus_read(A_CTRL, rd);
    n_checks++;
    if (rd !== 32'h2) $display("FAIL reserved_write_ctrl: got 0x%0h want 0x2", rd); else n_pass++;
    bus_read(A_STAT, rd);
    n_checks++;
    if (rd !== 32'h2) $display("FAIL reserved_write_status: got 0x%0h want 0x2", rd); else n_pass++;
    bus_read(A_DATA, rd);
    n_checks++;
    if (rd !== 32'h0) $display("FAIL data_read: got 0x%0h want 0x0", rd); else n_pass++;
    bus_write(A_CTRL, 32'h0);
  endtask

  task automatic test_frame_a5();
    logic [7:0] q[$];
    int ih;
    q.push_back(8'hA5);
    bus_write(A_CTRL, 32'h1);
    bus_write(A_DATA, 32'hA5);
    run_frames("a5", q, -1, 32'h0, 32'h0, -1, 32'h0, 32'h0, -1, 4'h0, ih);
  endtask

  task automatic test_random_frames();
    logic [7:0]  q[$];
    logic [7:0]  b;
    logic [31:0] rd;
    int n, ih;
    for (int it = 0; it < 3; it++) begin
      q.delete();
      bus_write(A_CTRL, 32'h0);
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        q.push_back(b);
        bus_write(A_DATA, {24'h0, b});
      end
      bus_write(A_CTRL, 32'h1);
      run_frames("random", q, -1, 32'h0, 32'h0, -1, 32'h0, 32'h0, -1, 4'h0, ih);
      @(negedge clk);
      bus_read(A_STAT, rd);
      n_checks++;
      if (rd !== 32'h2) $display("FAIL random_drained_status: got 0x%0h want 0x2", rd); else n_pass++;
    end
  endtask

  task automatic test_overflow();
    logic [7:0]  q[$];
    logic [7:0]  b;
    logic [31:0] rd;
    int ih;
    bus_write(A_CTRL, 32'h0);
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      if (i < 4) q.push_back(b);
      bus_write(A_DATA, {24'h0, b});
    end
    bus_read(A_STAT, rd);
    n_checks++;
    if (rd !== 32'hD) $display("FAIL overflow_status: got 0x%0h want 0xD", rd); else n_pass++;
    bus_write(A_STAT, 32'h7);
    bus_read(A_STAT, rd);
    n_checks++;
    if (rd !== 32'hD) $display("FAIL overflow_no_clear: got 0x%0h want 0xD", rd); else n_pass++;
    bus_write(A_STAT, 32'h8);
    bus_read(A_STAT, rd);
    n_checks++;
    if (rd !== 32'h5) $display("FAIL overflow_cleared: got 0x%0h want 0x5", rd); else n_pass++;
    bus_write(A_CTRL, 32'h1);
    run_frames("overflow_b2b", q, -1, 32'h0, 32'h0, -1, 32'h0, 32'h0, -1, 4'h0, ih);
    @(negedge clk);
    bus_read(A_STAT, rd);
    n_checks++;
    if (rd !== 32'h2) $display("FAIL overflow_drained: got 0x%0h want 0x2", rd); else n_pass++;
  endtask

  task automatic test_push_on_pop();
    logic [7:0]  q[$];
    logic [7:0]  b;
    logic [31:0] rd;
    int ih;
    bus_write(A_CTRL, 32'h0);
    for (int i = 0; i < 6; i++) q.push_back(8'($urandom));
    for (int i = 0; i < 4; i++) bus_write(A_DATA, {24'h0, q[i]});
    bus_write(A_CTRL, 32'h1);
    // refill to full during frame 0, then push on the exact cycle of the STOP->START pop
    run_frames("push_on_pop", q, 20, A_DATA, {24'h0, q[4]}, 10*DIV - 1, A_DATA, {24'h0, q[5]},
               10*DIV - 2, 4'h5, ih);
    @(negedge clk);
    bus_read(A_STAT, rd);
    n_checks++;
    if (rd !== 32'h2) $display("FAIL push_on_pop_status: got 0x%0h want 0x2", rd); else n_pass++;
    b = 8'h0;
  endtask

  task automatic test_irq();
    logic [7:0] q[$];
    int ih;
    q.push_back(8'($urandom));
    bus_write(A_CTRL, 32'h3);
    n_checks++;
    if (irq !== 1'b0) $display("FAIL irq_delay_rise: got %b want 0", irq); else n_pass++;
    @(negedge clk);
    n_checks++;
    if (irq !== 1'b1) $display("FAIL irq_idle_empty: got %b want 1", irq); else n_pass++;
    bus_write(A_DATA, {24'h0, q[0]});
    n_checks++;
    if (irq !== 1'b1) $display("FAIL irq_delay_fall: got %b want 1", irq); else n_pass++;
    run_frames("irq", q, -1, 32'h0, 32'h0, -1, 32'h0, 32'h0, -1, 4'h0, ih);
    n_checks++;
    if (ih != 0) $display("FAIL irq_during_frame: high for %0d cycles want 0", ih); else n_pass++;
    @(negedge clk);
    n_checks++;
    if (irq !== 1'b0) $display("FAIL irq_first_idle_cycle: got %b want 0", irq); else n_pass++;
    @(negedge clk);
    n_checks++;
    if (irq !== 1'b1) $display("FAIL irq_after_idle: got %b want 1", irq); else n_pass++;
    bus_write(A_CTRL, 32'h1);
  endtask

  task automatic test_disable_mid_frame();
    logic [7:0]  q0[$], q1[$];
    logic [31:0] rd;
    int ih, lows;
    q0.push_back(8'($urandom));
    q1.push_back(8'($urandom));
    bus_write(A_CTRL, 32'h0);
    bus_write(A_DATA, {24'h0, q0[0]});
    bus_write(A_DATA, {24'h0, q1[0]});
    bus_write(A_CTRL, 32'h1);
    run_frames("disable_mid", q0, 10, A_CTRL, 32'h0, -1, 32'h0, 32'h0, -1, 4'h0, ih);
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    n_checks++;
    if (lows != 0) $display("FAIL disable_held: txd low %0d cycles want 0", lows); else n_pass++;
    bus_read(A_STAT, rd);
    n_checks++;
    if (rd !== 32'h4) $display("FAIL disable_status: got 0x%0h want 0x4", rd); else n_pass++;
    bus_write(A_CTRL, 32'h1);
    run_frames("disable_resume", q1, -1, 32'h0, 32'h0, -1, 32'h0, 32'h0, -1, 4'h0, ih);
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] rd;
    int lows;
    bus_write(A_CTRL, 32'h1);
    bus_write(A_DATA, 32'h5A);
    bus_write(A_DATA, 32'h3C);
    n_checks++;
    if (txd !== 1'b0) $display("FAIL rstmid_in_start: got %b want 0", txd); else n_pass++;
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (txd !== 1'b1) $display("FAIL rstmid_txd_async: got %b want 1", txd); else n_pass++;
    bus_read(A_STAT, rd);
    n_checks++;
    if (rd !== 32'h2) $display("FAIL rstmid_status: got 0x%0h want 0x2", rd); else n_pass++;
    bus_read(A_CTRL, rd);
    n_checks++;
    if (rd !== 32'h0) $display("FAIL rstmid_ctrl: got 0x%0h want 0x0", rd); else n_pass++;
    n_checks++;
    if (irq !== 1'b0) $display("FAIL rstmid_irq: got %b want 0", irq); else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    bus_write(A_CTRL, 32'h1);
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    n_checks++;
    if (lows != 0) $display("FAIL rstmid_fifo_flushed: txd low %0d cycles want 0", lows); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_addr_decode();
    test_frame_a5();
    test_random_frames();
    test_overflow();
    test_push_on_pop();
    test_irq();
    test_disable_mid_frame();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
